aud_sram_arbiter: RTL and testbench

AUD_SRAM_ARBITER -- requirements
Module: aud_sram_arbiter

---
 rtl/aud_pkg.sv | 14 +
 rtl/aud_sram_arbiter.sv | 118 +++++++++++
 tb/tb_aud_sram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared types and widths for the audio SRAM arbiter.
package aud_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/aud_sram_arbiter.sv
// Arbitrates recorder writes and player reads onto one asynchronous SRAM.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the recorder always wins ties.
module aud_sram_arbiter
    import aud_pkg::*;
#(
    parameter int ACC_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rec_req,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    output logic              o_rec_ack,
    input  logic              i_play_req,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic [DATA_W-1:0] o_play_data,
    output logic              o_play_ack,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n,
    output logic              o_busy,
    output logic [1:0]        o_state
);

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] wdata;
    logic              grant_play;
    logic              sel_play;
    logic              any_req;
    logic              in_access;

`ifdef ARB_RR_EN
    logic last_play;

    // Remembers who won the previous grant; starting at "player" lets the recorder take the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_play <= 1'b1;
        end else if (state == S_IDLE && any_req) begin
            last_play <= sel_play;
        end
    end

    assign sel_play = i_play_req & (~i_rec_req | ~last_play);
`else
    assign sel_play = i_play_req & ~i_rec_req;
`endif

    assign any_req = i_rec_req | i_play_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (any_req) state_nxt = sel_play ? S_RD : S_WR;
            S_WR, S_RD: if (cnt == CNT_LAST) state_nxt = S_ACK;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Grant-time latching keeps later address/data wiggles on the request ports out of the access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= 4'd0;
            o_sram_addr <= '0;
            wdata       <= '0;
            grant_play  <= 1'b0;
            o_play_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        cnt         <= 4'd0;
                        grant_play  <= sel_play;
                        o_sram_addr <= sel_play ? i_play_addr : i_rec_addr;
                        if (!sel_play) wdata <= i_rec_data;
                    end
                end
                S_WR, S_RD: begin
                    cnt <= cnt + 4'd1;
                    if (state == S_RD && cnt == CNT_LAST) o_play_data <= io_sram_dq;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset releases the bus immediately.
    assign in_access   = (state == S_WR) || (state == S_RD);
    assign o_sram_ce_n = ~in_access;
    assign o_sram_lb_n = ~in_access;
    assign o_sram_ub_n = ~in_access;
    assign o_sram_we_n = (state != S_WR);
    assign o_sram_oe_n = (state != S_RD);
    assign io_sram_dq  = (state == S_WR) ? wdata : 'z;

    assign o_rec_ack  = (state == S_ACK) && !grant_play;
    assign o_play_ack = (state == S_ACK) && grant_play;
    assign o_busy     = (state != S_IDLE);
    assign o_state    = state;

endmodule

// File: tb/tb_aud_sram_arbiter.sv
// Randomized and directed checks of aud_sram_arbiter against a transaction-level model.
module tb_aud_sram_arbiter;
    import aud_pkg::*;

    localparam int ACC = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        preload = 1'b1;
    logic        rec_req = 1'b0, play_req = 1'b0;
    logic [19:0] rec_addr = '0, play_addr = '0;
    logic [15:0] rec_data = '0;
    wire         rec_ack, play_ack, ce_n, oe_n, we_n, lb_n, ub_n, busy;
    wire  [15:0] play_data, sram_dq;
    wire  [19:0] sram_addr;
    wire  [1:0]  state;

    logic        p1_req = 1'b0;
    logic [19:0] p1_addr = '0;
    wire         r1_ack, p1_ack, ce1_n, oe1_n, we1_n, lb1_n, ub1_n, busy1;
    wire  [15:0] pd1, dq1;
    wire  [19:0] addr1;
    wire  [1:0]  state1;

    logic [15:0] sram_mem [64];
    logic [15:0] ref_mem [64];
    int          total = 0, bad = 0, cyc = 0;
    bit          model_last_play = 1'b1;
    logic [15:0] last_read = '0;
    logic [19:0] last_addr = '0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    aud_sram_arbiter #(.ACC_CYC(ACC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
        .i_play_req(play_req), .i_play_addr(play_addr), .o_play_data(play_data), .o_play_ack(play_ack),
        .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n),
        .o_busy(busy), .o_state(state)
    );

    aud_sram_arbiter #(.ACC_CYC(1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rec_req(1'b0), .i_rec_addr(20'd0), .i_rec_data(16'd0), .o_rec_ack(r1_ack),
        .i_play_req(p1_req), .i_play_addr(p1_addr), .o_play_data(pd1), .o_play_ack(p1_ack),
        .o_sram_addr(addr1), .io_sram_dq(dq1),
        .o_sram_ce_n(ce1_n), .o_sram_oe_n(oe1_n), .o_sram_we_n(we1_n), .o_sram_lb_n(lb1_n), .o_sram_ub_n(ub1_n),
        .o_busy(busy1), .o_state(state1)
    );

    function automatic logic [15:0] pat(int i);
        if (i == 32) return 16'h1234;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] pat1(logic [19:0] a);
        return {a[3:0], 12'hC3A};
    endfunction

    // Behavioural SRAM devices on both buses.
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[5:0]] : 16'bz;
    assign dq1     = (!ce1_n && !oe1_n && we1_n) ? pat1(addr1) : 16'bz;

    always @(posedge i_clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= pat(i);
        end else if (!ce_n && !we_n) begin
            sram_mem[sram_addr[5:0]] <= sram_dq;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Winner of the next grant from the arbitration rules alone.
    function automatic bit predict(bit r, bit p);
        if (r && p) begin
`ifdef ARB_RR_EN
            return !model_last_play;
`else
            return 1'b0;
`endif
        end
        return p;
    endfunction

    task automatic idle_check(input string tag);
        check({tag, ".state"}, 32'(state), 32'(S_IDLE));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".acks"}, 32'({rec_ack, play_ack}), 32'd0);
        check({tag, ".strobes"}, 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        check({tag, ".addr_hold"}, 32'(sram_addr), 32'(last_addr));
        check({tag, ".data_hold"}, 32'(play_data), 32'(last_read));
    endtask

    // Called #1 after the grant edge; returns #1 into the ack cycle with the served req dropped.
    task automatic serve(input bit is_play, input logic [19:0] a, input logic [15:0] d,
                         input bit drop_early, input string tag);
        for (int j = 0; j < ACC; j++) begin
            check({tag, ".acc_state"}, 32'(state), is_play ? 32'd2 : 32'd1);
            check({tag, ".acc_strobes"}, 32'({ce_n, oe_n, we_n, lb_n, ub_n}), is_play ? 32'h04 : 32'h08);
            check({tag, ".acc_addr"}, 32'(sram_addr), 32'(a));
            check({tag, ".acc_acks"}, 32'({rec_ack, play_ack}), 32'd0);
            if (!is_play) check({tag, ".acc_dq"}, 32'(sram_dq), 32'(d));
            if (j == 0) begin
                if (is_play) begin
                    play_addr = play_addr ^ 20'hFFFFF;
                    if (drop_early) play_req = 1'b0;
                end else begin
                    rec_addr = rec_addr ^ 20'hFFFFF;
                    rec_data = ~rec_data;
                    if (drop_early) rec_req = 1'b0;
                end
            end
            tick();
        end
        check({tag, ".ack_state"}, 32'(state), 32'(S_ACK));
        check({tag, ".ack_rec"}, 32'(rec_ack), is_play ? 32'd0 : 32'd1);
        check({tag, ".ack_play"}, 32'(play_ack), is_play ? 32'd1 : 32'd0);
        check({tag, ".ack_strobes"}, 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        if (is_play) begin
            check({tag, ".rdata"}, 32'(play_data), 32'(ref_mem[a[5:0]]));
            last_read = ref_mem[a[5:0]];
            play_req = 1'b0;
        end else begin
            ref_mem[a[5:0]] = d;
            rec_req = 1'b0;
        end
        model_last_play = is_play;
        last_addr = a;
    endtask

    task automatic read1(input logic [19:0] a, output int ack_cyc, output int strobes,
                         output logic [15:0] data);
        p1_req = 1'b1;
        p1_addr = a;
        strobes = 0;
        ack_cyc = -1;
        data = '0;
        for (int i = 0; i < 10 && ack_cyc < 0; i++) begin
            tick();
            if (!oe1_n) strobes++;
            if (p1_ack) begin
                ack_cyc = cyc;
                data = pd1;
                p1_req = 1'b0;
            end
        end
        check("b2b.ack_seen", 32'(ack_cyc >= 0), 32'd1);
    endtask

    initial begin
        int c0, c1, s0, s1;
        logic [15:0] d0, d1;

        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
        repeat (3) @(posedge i_clk);
        #1;
        check("rst.state", 32'(state), 32'(S_IDLE));
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        check("rst.addr", 32'(sram_addr), 32'd0);
        check("rst.pdata", 32'(play_data), 32'd0);
        check("rst.acks", 32'({rec_ack, play_ack}), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        preload = 1'b0;
        tick();
        idle_check("post_rst");

        $display("[TB] single write");
        @(negedge i_clk);
        rec_req = 1'b1; rec_addr = 20'h00010; rec_data = 16'hA5A5;
        tick();
        serve(1'b0, 20'h00010, 16'hA5A5, 1'b0, "wr");
        tick();
        idle_check("wr.after");

        $display("[TB] single read");
        @(negedge i_clk);
        play_req = 1'b1; play_addr = 20'h00020;
        tick();
        serve(1'b1, 20'h00020, 16'h0, 1'b0, "rd");
        check("rd.const", 32'(play_data), 32'h1234);
        tick();
        idle_check("rd.after");

        $display("[TB] simultaneous requests held");
        model_last_play = 1'b1;
        @(negedge i_clk);
        rec_req = 1'b1; rec_addr = 20'h00003; rec_data = 16'h0BAD;
        play_req = 1'b1; play_addr = 20'h00010;
        tick();
        for (int k = 0; k < 4; k++) begin
            bit w;
            w = predict(rec_req, play_req);
`ifdef ARB_RR_EN
            check("arb.order", 32'(state), (k % 2 == 0) ? 32'd1 : 32'd2);
`else
            check("arb.order", 32'(state), 32'd1);
`endif
            serve(w, w ? play_addr : rec_addr, rec_data, 1'b0, "arb");
            tick();
            if (w) begin play_req = 1'b1; play_addr = 20'h00010; end
            else begin rec_req = 1'b1; rec_addr = 20'h00003; rec_data = 16'h0BAD; end
            tick();
        end
        rec_req = 1'b0; play_req = 1'b0;
        repeat (ACC + 2) tick();
        last_addr = sram_addr;
        model_last_play = (state == S_IDLE) ? model_last_play : model_last_play;
        idle_check("arb.drain");

        $display("[TB] request dropped mid-access");
        @(negedge i_clk);
        rec_req = 1'b1; rec_addr = 20'h00007; rec_data = 16'h7777;
        tick();
        serve(1'b0, 20'h00007, 16'h7777, 1'b1, "drop");
        tick();
        idle_check("drop.after");

        $display("[TB] reset during write");
        @(negedge i_clk);
        rec_req = 1'b1; rec_addr = 20'h00005; rec_data = 16'h5EED;
        tick();
        check("rst_mid.state_wr", 32'(state), 32'(S_WR));
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_mid.strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        check("rst_mid.state", 32'(state), 32'(S_IDLE));
        check("rst_mid.ack", 32'(rec_ack), 32'd0);
        check("rst_mid.pdata", 32'(play_data), 32'd0);
        model_last_play = 1'b1; last_read = '0; last_addr = '0;
        @(negedge i_clk);
        check("rst_mid.ack_held", 32'(rec_ack), 32'd0);
        i_rst_n = 1'b1;
        tick();
        serve(1'b0, 20'h00005, 16'h5EED, 1'b0, "rst_wr");
        tick();
        @(negedge i_clk);
        play_req = 1'b1; play_addr = 20'h00005;
        tick();
        serve(1'b1, 20'h00005, 16'h0, 1'b0, "rst_rd");
        check("rst_rd.const", 32'(play_data), 32'h5EED);
        tick();
        idle_check("rst.after");

        $display("[TB] randomized traffic");
        for (int r = 0; r < 40; r++) begin
            bit rq, pq, w;
            logic [19:0] ra, pa;
            logic [15:0] rd;
            rq = 1'($urandom_range(0, 1));
            pq = 1'($urandom_range(0, 1));
            ra = 20'($urandom_range(0, 63));
            pa = 20'($urandom_range(0, 63));
            rd = 16'($urandom);
            @(negedge i_clk);
            rec_req = rq; rec_addr = ra; rec_data = rd;
            play_req = pq; play_addr = pa;
            tick();
            if (!rq && !pq) begin
                idle_check("rnd.none");
                continue;
            end
            w = predict(rq, pq);
            serve(w, w ? pa : ra, rd, 1'b0, "rnd");
            tick();
            idle_check("rnd.gap");
            if (rq && pq) begin
                tick();
                serve(!w, w ? ra : pa, rd, 1'b0, "rnd2");
                tick();
                idle_check("rnd.end");
            end
        end

        $display("[TB] back-to-back reads with one-cycle strobe");
        @(negedge i_clk);
        read1(20'h00000, c0, s0, d0);
        tick();
        read1(20'h00001, c1, s1, d1);
        check("b2b.strobe0", 32'(s0), 32'd1);
        check("b2b.strobe1", 32'(s1), 32'd1);
        check("b2b.data0", 32'(d0), 32'(pat1(20'h00000)));
        check("b2b.data1", 32'(d1), 32'(pat1(20'h00001)));
        check("b2b.spacing", 32'(c1 - c0), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
